// File: rtl/inst_fetch.sv
// Program counter and fetch unit: drives the ROM address, captures the returned
// word for decode, and applies branches, stalls and halts under a Start/Done handshake.
module inst_fetch #(
  parameter int           A         = 10,
  parameter int           W         = 9,
  parameter logic [A-1:0] RESET_PC  = '0,
  parameter logic [W-1:0] HALT_WORD = '1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [A-1:0] BranchTarget,
  input  logic [W-1:0] InstIn,
  output logic [A-1:0] InstAddress,
  output logic [W-1:0] InstReg,
  output logic [A-1:0] InstRegAddr,
  output logic         InstValid,
  output logic         Done,
  output logic [15:0]  CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [W-1:0] inst;
    logic [A-1:0] addr;
    logic         valid;
  } if_id_t;

  state_e       state_q;
  logic [A-1:0] pc_q;
  if_id_t       dec_q;
  logic         done_q;
  logic [15:0]  cnt_q;

  logic [A-1:0] pc_inc_d;
  logic [A-1:0] br_pc_d;
  logic [15:0]  cnt_inc_d;
  logic         is_halt_d;
  logic         take_br_d;

  always_comb begin
    pc_inc_d  = pc_q + 1'b1;
    br_pc_d   = BranchRel ? dec_q.addr + BranchTarget
                          : BranchTarget;
    cnt_inc_d = (cnt_q == 16'hFFFF) ? cnt_q
                                    : cnt_q + 16'd1;
    is_halt_d = dec_q.valid && (dec_q.inst == HALT_WORD);
    take_br_d = dec_q.valid && BranchEn;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      dec_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            dec_q.valid <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_inc_d;
          // Stall drops any branch; decode re-presents it afterwards.
          if (Stall) begin
            pc_q <= pc_q;
          end else if (is_halt_d) begin
            state_q     <= S_HALT;
            dec_q.valid <= 1'b0;
            done_q      <= 1'b1;
          end else if (take_br_d) begin
            pc_q        <= br_pc_d;
            dec_q.valid <= 1'b0;
          end else begin
            dec_q.inst  <= InstIn;
            dec_q.addr  <= pc_q;
            dec_q.valid <= 1'b1;
            pc_q        <= pc_inc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign InstReg     = dec_q.inst;
  assign InstRegAddr = dec_q.addr;
  assign InstValid   = dec_q.valid;
  assign Done        = done_q;
  assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized bench for inst_fetch against a cycle-level
// reference of the fetch rules, with a combinational ROM array.
module tb_inst_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       ben;
  logic       brel;
  logic [9:0] btgt;
  logic [8:0] inst_in;
  logic [9:0] addr;
  logic [8:0] ir;
  logic [9:0] ira;
  logic       iv;
  logic       done;
  logic [15:0] cnt;

  logic [8:0] rom [1024];

  int n_vec;
  int n_err;

  // reference state: mode 0=idle 1=run 2=halt
  int         m_mode;
  logic [9:0] m_pc;
  logic [8:0] m_ir;
  logic [9:0] m_ira;
  logic       m_iv;
  logic       m_done;
  int         m_cnt;

  inst_fetch dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .Start        (start),
    .Stall        (stall),
    .BranchEn     (ben),
    .BranchRel    (brel),
    .BranchTarget (btgt),
    .InstIn       (inst_in),
    .InstAddress  (addr),
    .InstReg      (ir),
    .InstRegAddr  (ira),
    .InstValid    (iv),
    .Done         (done),
    .CycleCount   (cnt)
  );

  assign inst_in = rom[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = '0;
    m_ir   = '0;
    m_ira  = '0;
    m_iv   = 1'b0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    if (m_mode == 1) begin
      if (m_cnt < 65535) m_cnt++;
      if (stall) begin
        m_cnt = m_cnt;
      end else if (m_iv && m_ir == 9'h1FF) begin
        m_mode = 2;
        m_iv   = 1'b0;
        m_done = 1'b1;
      end else if (m_iv && ben) begin
        m_pc = brel ? 10'(m_ira + btgt) : btgt;
        m_iv = 1'b0;
      end else begin
        m_ir  = rom[m_pc];
        m_ira = m_pc;
        m_iv  = 1'b1;
        m_pc  = 10'(m_pc + 1);
      end
    end else if (start) begin
      m_mode = 1;
      m_pc   = '0;
      m_iv   = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"}, 32'(addr), 32'(m_pc));
    chk({tag, ".valid"}, 32'(iv), 32'(m_iv));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
    if (m_iv || m_mode != 1) begin
      chk({tag, ".ir"}, 32'(ir), 32'(m_ir));
      chk({tag, ".ira"}, 32'(ira), 32'(m_ira));
    end
  endtask

  task automatic step(input string tag, input logic st, input logic sl,
                      input logic be, input logic br, input logic [9:0] tg);
    start = st;
    stall = sl;
    ben   = be;
    brel  = br;
    btgt  = tg;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  logic [15:0] cnt_snap;
  logic [8:0]  ir_snap;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    ben   = 1'b0;
    brel  = 1'b0;
    btgt  = '0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle0", 1'b0, 1'b1, 1'b1, 1'b0, 10'h055);
    step("idle1", 1'b0, 1'b0, 1'b1, 1'b1, 10'h012);

    // basic run to halt
    rom[0] = 9'h011;
    rom[1] = 9'h022;
    rom[2] = 9'h1FF;
    step("t1.start", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step("t1.e1", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("t1.ir0", 32'(ir), 32'h011);
    step("t1.e2", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("t1.ir1", 32'(ir), 32'h022);
    step("t1.e3", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step("t1.e4", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("t1.addr3", 32'(addr), 32'd3);
    chk("t1.cnt4", 32'(cnt), 32'd4);
    chk("t1.done", 32'(done), 32'd1);
    step("t1.hold", 1'b0, 1'b1, 1'b1, 1'b0, 10'h100);

    // absolute branch at address 5
    for (int i = 0; i < 10; i++) rom[i] = 9'(i + 'h10);
    rom[10'h100] = 9'h0AB;
    step("t2.start", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step("t2.seq", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("t2.ira5", 32'(ira), 32'd5);
    step("t2.br", 1'b0, 1'b0, 1'b1, 1'b0, 10'h100);
    chk("t2.addr", 32'(addr), 32'h100);
    chk("t2.bubble", 32'(iv), 32'd0);
    step("t2.tgt", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("t2.ir", 32'(ir), 32'h0AB);

    // relative branches incl. wrap
    step("t3.abs", 1'b0, 1'b0, 1'b1, 1'b0, 10'h010);
    step("t3.f10", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step("t3.rel", 1'b0, 1'b0, 1'b1, 1'b1, 10'h3FC);
    chk("t3.pc00c", 32'(addr), 32'h00C);
    step("t3.f0c", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step("t3.abs3ff", 1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF);
    step("t3.f3ff", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("t3.seqwrap", 32'(addr), 32'h000);
    step("t3.relwrap", 1'b0, 1'b0, 1'b1, 1'b1, 10'h002);
    chk("t3.pc001", 32'(addr), 32'h001);

    // stall with branch held
    rom[10'h200] = 9'h1FF;
    step("t4.f1", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cnt_snap = cnt;
    ir_snap  = ir;
    for (int i = 0; i < 3; i++) step("t4.stall", 1'b0, 1'b1, 1'b1, 1'b0, 10'h200);
    chk("t4.cnt3", 32'(cnt), 32'(cnt_snap + 16'd3));
    chk("t4.irhold", 32'(ir), 32'(ir_snap));
    chk("t4.pchold", 32'(addr), 32'h002);
    step("t4.br", 1'b0, 1'b0, 1'b1, 1'b0, 10'h200);
    chk("t4.taken", 32'(addr), 32'h200);

    // halt beats branch, then restart
    step("t5.f200", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step("t5.halt", 1'b0, 1'b0, 1'b1, 1'b0, 10'h050);
    chk("t5.done", 32'(done), 32'd1);
    chk("t5.nobr", 32'(addr), 32'h201);
    step("t5.restart", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t5.pc0", 32'(addr), 32'h000);
    chk("t5.cnt0", 32'(cnt), 32'd0);

    // async reset mid-run
    step("t6.r1", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step("t6.r2", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.ir0", 32'(ir), 32'd0);
    #3;
    rst_n = 1'b1;
    step("t6.idle", 1'b0, 1'b0, 1'b1, 1'b0, 10'h123);
    step("t6.idle2", 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // randomized run
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 31) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int i = 0; i < 4000; i++)
      step("rnd",
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom),
           10'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
